// File: rtl/system_pll_pkg.sv
// Shared types and default cycle constants for the PLL reset sequencer.
// Holds the sequencer state encoding and a small helper used to size the shared counter.
package system_pll_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_SYNC_STAGES         = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/system_pll_sync.sv
// Multi-flop synchronizer for the asynchronous PLL lock flag; latency SYNC_STAGES refclk edges.
// clear_i synchronously empties the chain so a lock seen before a PLL reset is never reused.
module system_pll_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else if (clear_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/system_pll_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable synced lock, then releases sys_reset_n.
// All outputs are registered; sw_reset_req restarts the whole sequence from any state.
module system_pll_reset_seq
  import system_pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic [1:0] seq_state,
  output logic [7:0] lock_loss_count,
  output logic [7:0] timeout_count
);

  localparam int MAX_CYCLES = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pll_rst_q;
  logic          sys_reset_n_q;
  logic [7:0]    lock_loss_q;
  logic [7:0]    timeout_q;
  logic          lock_s;
  logic          lock_loss_inc;
  logic          timeout_inc;

  // Chain is held empty while the PLL is in reset, so lock must be re-observed afterwards.
  system_pll_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .clear_i(pll_rst_q),
    .async_i(pll_locked),
    .sync_o (lock_s)
  );

  always_comb begin
    state_d       = state_q;
    lock_loss_inc = 1'b0;
    timeout_inc   = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_PLL_RST;
          timeout_inc = !sw_reset_req;
        end
      end
      ST_STABLE: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d       = ST_PLL_RST;
          lock_loss_inc = 1'b1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
    if (sw_reset_req) state_d = ST_PLL_RST;
    if (sw_reset_req || (state_d != state_q)) cnt_d = '0;
    else cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lock_loss_q   <= 8'd0;
      timeout_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= (state_d == ST_PLL_RST);
      sys_reset_n_q <= (state_d == ST_RUN);
      if (lock_loss_inc && (lock_loss_q != 8'hFF)) lock_loss_q <= lock_loss_q + 8'd1;
      if (timeout_inc && (timeout_q != 8'hFF)) timeout_q <= timeout_q + 8'd1;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign seq_state       = state_q;
  assign lock_loss_count = lock_loss_q;
  assign timeout_count   = timeout_q;

endmodule
